// File: rtl/arb_req_agent.sv
// arb_req_agent: per-channel pending-request counters that feed a round-robin arbiter and turn grants into launch pulses.
// Optional per-channel starvation detection is compiled in when ARB_REQ_AGENT_STARVE_EN is defined.
module arb_req_agent #(
    parameter int N          = 4,
    parameter int DEPTH      = 8,
    parameter int STARVE_CYC = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] push,
    output logic [N-1:0] full,
    output logic [N-1:0] req,
    input  logic [N-1:0] grant,
    output logic [N-1:0] launch,
    output logic         pend_any,
    output logic         err,
    output logic [N-1:0] starve,
    input  logic         clr_flags
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    if (DEPTH < 1 || STARVE_CYC < 1) begin : g_param_check
        $error("arb_req_agent: DEPTH and STARVE_CYC must be >= 1");
    end

    logic [CW-1:0] cnt [N];
    logic [N-1:0]  acc;
    logic [N-1:0]  pv;
    logic          err_evt;

    // A push into a full channel is still taken when that channel is accepted in the same cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req[i]  = (cnt[i] != '0);
            full[i] = (cnt[i] == CNT_MAX);
        end
        acc      = grant & req;
        pv       = push & (~full | acc);
        launch   = acc;
        pend_any = |req;
        err_evt  = (|(push & ~pv)) | (|(grant & ~req));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pv[i] && !acc[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (acc[i] && !pv[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // A new error event wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_evt) begin
            err <= 1'b1;
        end else if (clr_flags) begin
            err <= 1'b0;
        end
    end

`ifdef ARB_REQ_AGENT_STARVE_EN
    localparam int WW = $clog2(STARVE_CYC + 1);
    localparam logic [WW-1:0] WC_SAT  = WW'(STARVE_CYC);
    localparam logic [WW-1:0] WC_LAST = WW'(STARVE_CYC - 1);

    logic [WW-1:0] wc [N];
    logic [N-1:0]  waiting;
    logic [N-1:0]  starve_evt;

    // The flag fires on the edge where the wait count reaches saturation, and again while it stays there.
    always_comb begin
        waiting = req & ~acc;
        for (int i = 0; i < N; i++) begin
            starve_evt[i] = waiting[i] && (wc[i] >= WC_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                wc[i] <= '0;
            end
            starve <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!waiting[i]) begin
                    wc[i] <= '0;
                end else if (wc[i] != WC_SAT) begin
                    wc[i] <= wc[i] + 1'b1;
                end
                if (starve_evt[i]) begin
                    starve[i] <= 1'b1;
                end else if (clr_flags) begin
                    starve[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign starve = '0;
`endif

endmodule

// File: tb/tb_arb_req_agent.sv
// Scoreboard bench for arb_req_agent: a queue-based reference model predicts every cycle's outputs.
// Starvation checks are compiled in when ARB_REQ_AGENT_STARVE_EN is defined.
module tb_arb_req_agent;
    localparam int N  = 4;
    localparam int DEPTH = 8;
    localparam int SC = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] push;
    logic [N-1:0] full;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] launch;
    logic         pend_any;
    logic         err;
    logic [N-1:0] starve;
    logic         clr_flags;

    arb_req_agent #(.N(N), .DEPTH(DEPTH), .STARVE_CYC(SC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .full(full),
        .req(req),
        .grant(grant),
        .launch(launch),
        .pend_any(pend_any),
        .err(err),
        .starve(starve),
        .clr_flags(clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] full;
        logic [N-1:0] launch;
        logic [N-1:0] starve;
        logic         pend;
        logic         err;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending requests per channel, sticky flags, and how long each channel has waited.
    int           m_pend[N];
    int           m_wait[N];
    logic         m_err    = 1'b0;
    logic [N-1:0] m_starve = '0;

    task automatic check_output(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_wait[i] = 0;
        end
        m_err    = 1'b0;
        m_starve = '0;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] p, input logic [N-1:0] g,
                                  input logic c, input logic r);
        exp_t         e;
        logic [N-1:0] served;
        logic         bad;
        logic         st_hit;
        @(posedge clk);
        #1;
        push      = p;
        grant     = g;
        clr_flags = c;
        rst_n     = r;
        if (!r) model_reset();
        for (int i = 0; i < N; i++) begin
            e.req[i]  = (m_pend[i] > 0);
            e.full[i] = (m_pend[i] == DEPTH);
        end
        served   = g & e.req;
        e.launch = served;
        e.pend   = |e.req;
        e.err    = m_err;
        e.starve = m_starve;
        sb.push_back(e);
        if (r) begin
            bad = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (g[i] && m_pend[i] == 0) bad = 1'b1;
                if (served[i]) m_pend[i] = m_pend[i] - 1;
                if (p[i]) begin
                    if (m_pend[i] < DEPTH) m_pend[i] = m_pend[i] + 1;
                    else bad = 1'b1;
                end
`ifdef ARB_REQ_AGENT_STARVE_EN
                st_hit = 1'b0;
                if (e.req[i] && !served[i]) begin
                    m_wait[i] = (m_wait[i] < SC) ? m_wait[i] + 1 : SC;
                    st_hit = (m_wait[i] == SC);
                end else begin
                    m_wait[i] = 0;
                end
                m_starve[i] = st_hit | (m_starve[i] & ~c);
`else
                st_hit = 1'b0;
                m_starve[i] = st_hit;
`endif
            end
            m_err = bad | (m_err & ~c);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare them against the oldest prediction.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            check_output("req",      req,      e_mon.req);
            check_output("full",     full,     e_mon.full);
            check_output("launch",   launch,   e_mon.launch);
            check_output("starve",   starve,   e_mon.starve);
            check_output("pend_any", {{(N-1){1'b0}}, pend_any}, {{(N-1){1'b0}}, e_mon.pend});
            check_output("err",      {{(N-1){1'b0}}, err},      {{(N-1){1'b0}}, e_mon.err});
        end
    end

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) apply_stimulus('0, '0, 1'b0, 1'b1);
    endtask

    logic [N-1:0] rp;
    logic [N-1:0] rg;
    int           sel;

    initial begin
        rst_n     = 1'b0;
        push      = '0;
        grant     = '0;
        clr_flags = 1'b0;
        model_reset();
        $display("[TB] start");

        apply_stimulus('0, '0, 1'b0, 1'b0);
        apply_stimulus('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("reset_req", req, 4'b0000);
        idle(1);

        for (int k = 0; k < 3; k++) apply_stimulus(4'b0001, '0, 1'b0, 1'b1);
        idle(1);
        @(negedge clk);
        check_output("burst_req", req, 4'b0001);

        for (int k = 0; k < 3; k++) begin
            apply_stimulus('0, 4'b0001, 1'b0, 1'b1);
            @(negedge clk);
            check_output("grant_launch", launch, 4'b0001);
        end
        idle(1);
        @(negedge clk);
        check_output("drained_req", req, 4'b0000);

        for (int k = 0; k < 9; k++) apply_stimulus(4'b0100, '0, 1'b0, 1'b1);
        idle(1);
        @(negedge clk);
        check_output("overflow_full", full, 4'b0100);
        check_output("overflow_err", {3'b000, err}, 4'b0001);
        apply_stimulus('0, '0, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        check_output("clr_err", {3'b000, err}, 4'b0000);

        for (int k = 0; k < 8; k++) apply_stimulus(4'b0010, '0, 1'b0, 1'b1);
        apply_stimulus(4'b0010, 4'b0010, 1'b0, 1'b1);
        @(negedge clk);
        check_output("full_pg_launch", launch, 4'b0010);
        idle(1);
        @(negedge clk);
        check_output("full_pg_full", full, 4'b0110);
        check_output("full_pg_err", {3'b000, err}, 4'b0000);

        apply_stimulus('0, 4'b1000, 1'b0, 1'b1);
        @(negedge clk);
        check_output("spurious_launch", launch, 4'b0000);
        idle(1);
        @(negedge clk);
        check_output("spurious_err", {3'b000, err}, 4'b0001);

        for (int k = 0; k < 1500; k++) begin
            rp  = (k < 750) ? N'($urandom & $urandom) : N'($urandom & $urandom & $urandom);
            sel = $urandom_range(0, 9);
            if (sel <= 5)      rg = N'(1) << $urandom_range(0, N - 1);
            else if (sel <= 7) rg = N'($urandom);
            else               rg = '0;
            apply_stimulus(rp, rg, ($urandom_range(0, 15) == 0), 1'b1);
        end

        for (int k = 0; k < 4; k++) apply_stimulus(4'b0111, '0, 1'b0, 1'b1);
        apply_stimulus(4'b0111, 4'b0110, 1'b0, 1'b0);
        #1;
        check_output("midreset_req", req, 4'b0000);
        check_output("midreset_launch", launch, 4'b0000);
        apply_stimulus('0, '0, 1'b0, 1'b0);
        idle(1);

`ifdef ARB_REQ_AGENT_STARVE_EN
        apply_stimulus(4'b0100, '0, 1'b0, 1'b1);
        apply_stimulus(4'b0100, '0, 1'b0, 1'b1);
        idle(8);
        apply_stimulus('0, 4'b0100, 1'b0, 1'b1);
        idle(4);
        apply_stimulus('0, 4'b0100, 1'b0, 1'b1);
        idle(1);
        @(negedge clk);
        check_output("starve_reset_by_grant", starve, 4'b0000);

        apply_stimulus(4'b0010, '0, 1'b0, 1'b1);
        idle(16);
        @(negedge clk);
        check_output("starve_before", starve, 4'b0000);
        idle(1);
        @(negedge clk);
        check_output("starve_after", starve, 4'b0010);
        apply_stimulus('0, 4'b0010, 1'b1, 1'b1);
        idle(1);
        @(negedge clk);
        check_output("starve_clr", starve, 4'b0000);
`else
        apply_stimulus(4'b0010, '0, 1'b0, 1'b1);
        idle(20);
        @(negedge clk);
        check_output("starve_disabled", starve, 4'b0000);
`endif

        idle(1);
        @(negedge clk);
        @(posedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
